fpu_add_arbiter: RTL
====================

# fpu_add_arbiter

Round-robin scheduler that shares one combinational single-precision `adder` (data1/data2 → result) among NUM_REQ requesters. Each requester uses a valid/ready request channel. The block registers the granted operands and drives them onto the shared adder. It captures the sum and returns it on a single response channel tagged with the requester ID. One operation is outstanding at a time. The adder is instantiated beside this block, in the FPU top level.

## Interface

**Parameters**
- NUM_REQ, 4: number of requesters (2..16).
- ID_W, $clog2(NUM_REQ): width of the requester ID.
- CNT_W, 16: width of the completed-operation counter.

**Ports**
- clk, in, 1: clock, rising edge.
- n_rst, in, 1: asynchronous active-low reset.
- req_valid, in, NUM_REQ: per-requester request valid.
- req_data1, in, 32*NUM_REQ: operand 1 for requester i, at bits [32*i+31:32*i].
- req_data2, in, 32*NUM_REQ: operand 2 for requester i, packed the same way.
- req_ready, out, NUM_REQ: one-hot grant/accept.
- add_data1, out, 32: to adder data1.
- add_data2, out, 32: to adder data2.
- add_result, in, 32: from adder result.
- rsp_valid, out, 1: response valid.
- rsp_ready, in, 1: response consumer ready.
- rsp_id, out, ID_W: index of the requester that issued the operation.
- rsp_result, out, 32: registered sum.
- busy, out, 1: high whenever state ≠ IDLE.
- ops_done, out, CNT_W: completed-response counter; wraps.

## Operation

The FSM has three states: IDLE, OPER, RESP.

**IDLE**
- Grant g is the first i with req_valid[i]=1, searching upward from rr_ptr modulo NUM_REQ.
- req_ready[g]=1 combinationally; all other req_ready bits are 0.
- On handshake: op1←data1[g], op2←data2[g], id←g, rr_ptr←(g+1) mod NUM_REQ, state→OPER.
- If no req_valid is high: stay in IDLE; rr_ptr is unchanged.

**OPER**
- add_data1/add_data2 = op1/op2. These outputs are always driven from the op registers, so they hold their last value in every state.
- At the end of the cycle: rsp_result←add_result, rsp_id←id, state→RESP.

**RESP**
- rsp_valid=1.
- On rsp_ready=1: ops_done←ops_done+1 (wraps at 2^CNT_W), state→IDLE.
- Otherwise hold rsp_valid, rsp_id and rsp_result stable.

**In every state**
- req_ready is all zero in OPER and RESP.
- rsp_ready is ignored when rsp_valid=0.

**Requester rules**
- A requester holds req_valid and its data stable until req_ready.
- Deasserting req_valid before the grant is legal; nothing is committed.

**Arbitration**
- Round-robin, work-conserving.
- A continuously requesting input waits at most NUM_REQ−1 other operations.

**Arithmetic**
- No arithmetic on the data; IEEE behaviour is entirely the adder's.

## Timing

**Reset values** (asynchronous, immediate on n_rst=0)
- State IDLE, rr_ptr=0.
- op1=op2=0, so add_data1=add_data2=0.
- rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, ops_done=0.
- req_ready=0 while n_rst=0.

**Latency**
- Request accepted at edge T (IDLE→OPER).
- rsp_valid=1 from cycle T+2 (after the OPER→RESP edge).
- Earliest next acceptance is the edge one cycle after the response handshake.
- Peak throughput: 1 operation per 3 cycles with rsp_ready held high.

**Reset mid-operation**
- An in-flight operation is discarded with no response, and ops_done is not incremented.
- After release, arbitration restarts from requester 0.

**Combinational path**
- The only combinational path is req_valid → req_ready.
- add_result is sampled only at the OPER→RESP edge.

## Test plan

1. **Reset:** assert n_rst=0 mid-cycle → all outputs read 0 immediately, including add_data1/add_data2 and ops_done.
2. **Single request:** requester 2 presents 0x42C86666 (100.2) + 0x42B50000 (90.5) → req_ready=4'b0100, add_data1=0x42C86666 during OPER, rsp_valid two cycles after acceptance with rsp_id=2 and rsp_result=0x433EB333. With rsp_ready=1, ops_done=1 and busy falls.
3. **Round-robin ordering:** all four requesters valid from reset with distinct operands (e.g. r1: 0x4249999A+0x42C9999A) → responses in ID order 0,1,2,3; r1's rsp_result=0x43173333. Then only r0 and r3 request → order 3,0 with rr_ptr=3 after r2.
4. **Backpressure:** r0 issues 0xC2ACFAE1+0xC4163852 with rsp_ready=0 for 5 cycles → rsp_valid=1, rsp_result=0xC42BD7AE and rsp_id=0 stable, req_ready=0 and busy=1 throughout. The pending r1 request is granted one cycle after rsp_ready rises.
5. **Reset during OPER:** n_rst pulsed low → rsp_valid never asserts for that operation and ops_done stays 0. The same request re-presented completes normally.
6. **Counter wrap:** with CNT_W=2, five back-to-back operations → ops_done sequence 1,2,3,0,1.

Source files
------------

// File: rtl/fpu_add_arbiter.sv
// Round-robin front end that shares one combinational FP adder among NUM_REQ
// requesters. Only one operation is in flight at a time: IDLE grants and
// captures operands, OPER lets the adder settle, RESP holds the tagged sum
// until the consumer takes it.
module fpu_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [32*NUM_REQ-1:0]   req_data1,
    input  logic [32*NUM_REQ-1:0]   req_data2,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [31:0]             add_data1,
    output logic [31:0]             add_data2,
    input  logic [31:0]             add_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_result,
    output logic                    busy,
    output logic [CNT_W-1:0]        ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    r_rsp_id;
    logic [31:0]        r_op1;
    logic [31:0]        r_op2;
    logic [31:0]        r_res;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_gnt_vld;
    logic [ID_W-1:0]    w_gnt;
    logic [ID_W-1:0]    w_idx;
    logic [ID_W+4:0]    w_sel;
    logic               w_accept;
    logic [ID_W-1:0]    w_ptr_next;

    // Round-robin pick: first valid requester at or above r_ptr, wrapping.
    // Scanning from the farthest offset down lets the nearest one win last.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        w_idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            if (req_valid[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = w_idx;
            end
        end
    end

    // Only IDLE accepts; ready is gated by reset so nothing leaks out while held.
    assign w_accept = (r_state == IDLE) && w_gnt_vld;

    // One-hot grant back to the chosen requester.
    always_comb begin
        req_ready = '0;
        if (n_rst && w_accept) begin
            req_ready[w_gnt] = 1'b1;
        end
    end

    // Bit offset of the granted operand slice (32 bits per requester).
    assign w_sel      = {w_gnt, 5'd0};
    assign w_ptr_next = (w_gnt == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_gnt_vld) w_next = OPER;
            OPER:    w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand capture, result capture and completion count; a reset drops
    // whatever was in flight without counting it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ptr    <= '0;
            r_id     <= '0;
            r_rsp_id <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_op1 <= req_data1[w_sel +: 32];
                r_op2 <= req_data2[w_sel +: 32];
                r_id  <= w_gnt;
                r_ptr <= w_ptr_next;
            end
            // add_result is only trusted after a full cycle on stable operands.
            if (r_state == OPER) begin
                r_res    <= add_result;
                r_rsp_id <= r_id;
            end
            if ((r_state == RESP) && rsp_ready) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign add_data1  = r_op1;
    assign add_data2  = r_op2;
    assign rsp_valid  = (r_state == RESP);
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_res;
    assign busy       = (r_state != IDLE);
    assign ops_done   = r_cnt;

endmodule
